soc_sysid_ext: RTL and testbench

SOC_SYSID_EXT -- requirements
Module: soc_sysid_ext

---
 rtl/soc_sysid_ext.sv | 178 +++++++++++++++++
 tb/tb_soc_sysid_ext.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_sysid_ext.sv
`default_nettype none
// ============================================================================
// Module      : soc_sysid_ext
// Description : System identification register block. It is a word-addressed
//               slave with a fixed one-cycle read latency. It returns a
//               system ID, a build timestamp, an optional 64-bit uptime
//               counter with a consistent-snapshot high word, a CTRL
//               register and NUM_USER read/write scratch words.
//
//               Word map:
//                 0         ID_VALUE                    (RO)
//                 1         TIMESTAMP                   (RO)
//                 2         UPTIME_LO                   (RO)
//                 3         UPTIME_HI shadow            (RO)
//                 4         CTRL  bit0 freeze, bit1 clear (RW)
//                 5..4+N    scratch                     (RW)
//               Any other address reads 0, and writes to it are ignored.
//
// Ports       : clock         - single rising-edge clock
//               reset         - synchronous, active-high reset
//               address[3:0]  - word address
//               read / write  - access strobes; read wins if both are set
//               writedata[31:0]
//               readdata[31:0]- registered read data, held between reads
//               readdatavalid - high for one cycle, one cycle after a read
//
// Build macro : SOC_SYSID_UPTIME_EN - when defined, adds the uptime counter,
//               the UPTIME_HI shadow and CTRL. When it is undefined,
//               addresses 2..4 read 0 and ignore writes.
//
// Revision    : 1.0 - initial release
// ============================================================================
module soc_sysid_ext #(
    parameter logic [31:0] ID_VALUE  = 32'd1729828992,
    parameter logic [31:0] TIMESTAMP = 32'd0,
    parameter int          NUM_USER  = 2            // legal 1..4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [3:0] c_addr_id      = 4'd0;
    localparam logic [3:0] c_addr_ts      = 4'd1;
`ifdef SOC_SYSID_UPTIME_EN
    localparam logic [3:0] c_addr_up_lo   = 4'd2;
    localparam logic [3:0] c_addr_up_hi   = 4'd3;
    localparam logic [3:0] c_addr_ctrl    = 4'd4;
`endif
    localparam int         c_scratch_base = 5;

    // A simultaneous read takes priority, so the write is dropped.
    logic w_wr_en;
    assign w_wr_en = write & ~read;

    // ------------------------------------------------------------------
    // Scratch words
    // ------------------------------------------------------------------
    logic [31:0] r_scratch_q [NUM_USER];
    logic [31:0] w_scratch_d [NUM_USER];

    always_comb begin
        for (int i = 0; i < NUM_USER; i++) begin
            w_scratch_d[i] = r_scratch_q[i];
            if (w_wr_en && (address == 4'(c_scratch_base + i))) begin
                w_scratch_d[i] = writedata;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_USER; i++) begin
            if (reset) begin
                r_scratch_q[i] <= 32'd0;
            end else begin
                r_scratch_q[i] <= w_scratch_d[i];
            end
        end
    end

`ifdef SOC_SYSID_UPTIME_EN
    // ------------------------------------------------------------------
    // Uptime counter, UPTIME_HI shadow and CTRL.freeze
    // ------------------------------------------------------------------
    logic [63:0] r_uptime_q;
    logic [63:0] w_uptime_d;
    logic [31:0] r_shadow_q;
    logic [31:0] w_shadow_d;
    logic        r_freeze_q;
    logic        w_freeze_d;

    always_comb begin
        w_uptime_d = r_freeze_q ? r_uptime_q : (r_uptime_q + 64'd1);
        w_freeze_d = r_freeze_q;
        w_shadow_d = r_shadow_q;
        if (w_wr_en && (address == c_addr_ctrl)) begin
            w_freeze_d = writedata[0];
            // Clear is a write-only pulse. It overrides the increment
            // and is never stored.
            if (writedata[1]) begin
                w_uptime_d = 64'd0;
            end
        end
        // The high word is captured with the low word being returned. A
        // later read of UPTIME_HI therefore belongs to the same snapshot.
        if (read && (address == c_addr_up_lo)) begin
            w_shadow_d = r_uptime_q[63:32];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_uptime_q <= 64'd0;
            r_shadow_q <= 32'd0;
            r_freeze_q <= 1'b0;
        end else begin
            r_uptime_q <= w_uptime_d;
            r_shadow_q <= w_shadow_d;
            r_freeze_q <= w_freeze_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [31:0] w_rd_word;

    always_comb begin
        w_rd_word = 32'd0;
        case (address)
            c_addr_id:    w_rd_word = ID_VALUE;
            c_addr_ts:    w_rd_word = TIMESTAMP;
`ifdef SOC_SYSID_UPTIME_EN
            c_addr_up_lo: w_rd_word = r_uptime_q[31:0];
            c_addr_up_hi: w_rd_word = r_shadow_q;
            c_addr_ctrl:  w_rd_word = {31'd0, r_freeze_q};
`endif
            default:      w_rd_word = 32'd0;
        endcase
        for (int i = 0; i < NUM_USER; i++) begin
            if (address == 4'(c_scratch_base + i)) begin
                w_rd_word = r_scratch_q[i];
            end
        end
    end

    logic [31:0] r_readdata_q;
    logic [31:0] w_readdata_d;
    logic        r_rdvalid_q;
    logic        w_rdvalid_d;

    // readdata holds its last value until the next read.
    always_comb begin
        w_rdvalid_d  = read;
        w_readdata_d = read ? w_rd_word : r_readdata_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_readdata_q <= 32'd0;
            r_rdvalid_q  <= 1'b0;
        end else begin
            r_readdata_q <= w_readdata_d;
            r_rdvalid_q  <= w_rdvalid_d;
        end
    end

    assign readdata      = r_readdata_q;
    assign readdatavalid = r_rdvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_sysid_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_sysid_ext
// Description : Self-checking bench for soc_sysid_ext. A behavioural register
//               map model predicts every response. It follows the
//               SOC_SYSID_UPTIME_EN macro in the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_sysid_ext;

    localparam logic [31:0] c_id = 32'd1729828992;
    localparam logic [31:0] c_ts = 32'd0;
    localparam int          c_nu = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  address = 4'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        readdatavalid;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    soc_sysid_ext dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    // ---------------- reference model ----------------
    logic [63:0] m_up;
    logic [31:0] m_shadow;
    logic        m_freeze;
    logic [31:0] m_scr [c_nu];
    logic [31:0] exp_rdata;
    logic        exp_rdv;

    function automatic logic [31:0] model_read(input int a);
        if (a == 0) return c_id;
        if (a == 1) return c_ts;
`ifdef SOC_SYSID_UPTIME_EN
        if (a == 2) return m_up[31:0];
        if (a == 3) return m_shadow;
        if (a == 4) return {31'd0, m_freeze};
`endif
        if (a >= 5 && a < 5 + c_nu) return m_scr[a-5];
        return 32'd0;
    endfunction

    // Applies one cycle of stimulus, advances the model and lands 1 ns after
    // the edge, where the outputs for that cycle can be compared.
    task automatic step(input bit rst, input bit rd, input bit wr,
                        input int a, input logic [31:0] wd);
        logic [63:0] nxt;
        reset = rst; read = rd; write = wr; address = 4'(a); writedata = wd;
        if (rst) begin
            m_up = 0; m_shadow = 0; m_freeze = 0;
            for (int i = 0; i < c_nu; i++) m_scr[i] = 0;
            exp_rdata = 0; exp_rdv = 0;
        end else begin
            nxt = m_freeze ? m_up : m_up + 64'd1;
            exp_rdv = rd;
            if (rd) begin
                exp_rdata = model_read(a);
                if (a == 2) m_shadow = m_up[63:32];
            end else if (wr) begin
`ifdef SOC_SYSID_UPTIME_EN
                if (a == 4) begin
                    m_freeze = wd[0];
                    if (wd[1]) nxt = 0;
                end
`endif
                if (a >= 5 && a < 5 + c_nu) m_scr[a-5] = wd;
            end
            m_up = nxt;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 5, 32'h1234_5678);   // accesses during reset are ignored
        total++;
        if (readdatavalid !== 1'b0) begin
            bad++; $display("FAIL reset_rdv actual=%b required=0", readdatavalid);
        end
        total++;
        if (readdata !== 32'd0) begin
            bad++; $display("FAIL reset_rdata actual=%h required=0", readdata);
        end
        step(0, 1, 0, 5, 0);
        total++;
        if (readdata !== 32'd0 || readdatavalid !== 1'b1) begin
            bad++; $display("FAIL reset_scratch actual=%h/%b required=0/1", readdata, readdatavalid);
        end
    endtask

    task automatic test_id;
        step(0, 1, 0, 0, 0);
        total++;
        if (readdata !== 32'd1729828992 || readdatavalid !== 1'b1) begin
            bad++; $display("FAIL id actual=%0d/%b required=1729828992/1", readdata, readdatavalid);
        end
        step(0, 1, 0, 1, 0);
        total++;
        if (readdata !== 32'd0 || readdatavalid !== 1'b1) begin
            bad++; $display("FAIL timestamp actual=%h/%b required=0/1", readdata, readdatavalid);
        end
        step(0, 0, 0, 0, 0);
        total++;
        if (readdatavalid !== 1'b0 || readdata !== 32'd0) begin
            bad++; $display("FAIL hold actual=%h/%b required=0/0", readdata, readdatavalid);
        end
    endtask

    task automatic test_scratch;
        step(0, 0, 1, 5, 32'hDEAD_BEEF);
        step(0, 1, 0, 5, 0);
        total++;
        if (readdata !== 32'hDEAD_BEEF || readdatavalid !== 1'b1) begin
            bad++; $display("FAIL scratch5 actual=%h required=deadbeef", readdata);
        end
        step(0, 1, 0, 15, 0);
        total++;
        if (readdata !== 32'd0 || readdatavalid !== 1'b1) begin
            bad++; $display("FAIL unmapped15 actual=%h required=0", readdata);
        end
        step(0, 0, 1, 0, 32'h5555_AAAA);
        step(0, 1, 0, 0, 0);
        total++;
        if (readdata !== c_id) begin
            bad++; $display("FAIL ro_write actual=%h required=%h", readdata, c_id);
        end
        step(0, 0, 1, 6, 32'h0BAD_F00D);
        step(0, 1, 0, 6, 0);
        total++;
        if (readdata !== 32'h0BAD_F00D) begin
            bad++; $display("FAIL scratch6 actual=%h required=0badf00d", readdata);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] got [3];
        logic        v [3];
        step(0, 1, 0, 0, 0);               got[0] = readdata; v[0] = readdatavalid;
        step(0, 1, 1, 1, 32'hFFFF_FFFF);   got[1] = readdata; v[1] = readdatavalid;
        step(0, 1, 0, 5, 0);               got[2] = readdata; v[2] = readdatavalid;
        total++;
        if (got[0] !== c_id || got[1] !== c_ts || got[2] !== 32'hDEAD_BEEF ||
            v[0] !== 1'b1 || v[1] !== 1'b1 || v[2] !== 1'b1) begin
            bad++;
            $display("FAIL back_to_back actual=%h,%h,%h valid=%b%b%b required=%h,%h,deadbeef valid=111",
                     got[0], got[1], got[2], v[0], v[1], v[2], c_id, c_ts);
        end
        step(0, 1, 0, 1, 0);
        total++;
        if (readdata !== c_ts) begin
            bad++; $display("FAIL dropped_write actual=%h required=%h", readdata, c_ts);
        end
    endtask

    task automatic test_random;
        int errs = 0;
        int a;
        for (int n = 0; n < 400; n++) begin
            a = int'($urandom_range(0, 15));
            step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a,
                 ($urandom_range(0, 3) == 0) ? {$urandom} & 32'h3 : $urandom);
            total++;
            if (readdatavalid !== exp_rdv || readdata !== exp_rdata) begin
                bad++;
                if (errs < 5)
                    $display("FAIL random[%0d] addr=%0d actual=%h/%b required=%h/%b",
                             n, a, readdata, readdatavalid, exp_rdata, exp_rdv);
                errs++;
            end
        end
    endtask

`ifdef SOC_SYSID_UPTIME_EN
    task automatic test_uptime;
        logic [31:0] lo1;
        // snapshot across a carry out of the low word
        force dut.r_uptime_q = 64'h0000_0001_FFFF_FFFF;
        #1;
        release dut.r_uptime_q;
        m_up = 64'h0000_0001_FFFF_FFFF;
        step(0, 1, 0, 2, 0);
        total++;
        if (readdata !== 32'hFFFF_FFFF || readdata !== exp_rdata) begin
            bad++; $display("FAIL snap_lo actual=%h required=ffffffff", readdata);
        end
        step(0, 1, 0, 3, 0);
        total++;
        if (readdata !== 32'h1) begin
            bad++; $display("FAIL snap_hi actual=%h required=1", readdata);
        end
        // freeze
        step(0, 0, 1, 4, 32'h1);
        idle(10);
        step(0, 1, 0, 2, 0);
        lo1 = readdata;
        idle(4);
        step(0, 1, 0, 2, 0);
        total++;
        if (readdata !== lo1 || readdata !== exp_rdata) begin
            bad++; $display("FAIL freeze actual=%h required=%h", readdata, exp_rdata);
        end
        step(0, 1, 0, 4, 0);
        total++;
        if (readdata !== 32'h1) begin
            bad++; $display("FAIL ctrl_rd actual=%h required=1", readdata);
        end
        // clear
        step(0, 0, 1, 4, 32'h2);
        step(0, 1, 0, 2, 0);
        total++;
        if (readdata !== 32'd0) begin
            bad++; $display("FAIL clear_lo actual=%h required=0", readdata);
        end
        step(0, 1, 0, 4, 0);
        total++;
        if (readdata !== 32'd0) begin
            bad++; $display("FAIL clear_ctrl actual=%h required=0", readdata);
        end
    endtask
`endif

    task automatic test_reset_after_read;
        step(0, 0, 1, 5, 32'hCAFE_0001);
        step(0, 1, 0, 5, 0);
        step(1, 0, 0, 0, 0);
        total++;
        if (readdatavalid !== 1'b0 || readdata !== 32'd0) begin
            bad++; $display("FAIL rst_after_read actual=%h/%b required=0/0", readdata, readdatavalid);
        end
        step(0, 0, 0, 0, 0);
        for (int a = 2; a <= 6; a++) begin
            step(0, 1, 0, a, 0);
            total++;
            if (readdata !== exp_rdata) begin
                bad++; $display("FAIL rst_regs addr=%0d actual=%h required=%h", a, readdata, exp_rdata);
            end
        end
    endtask

    initial begin
        test_reset;
        test_id;
        test_scratch;
        test_back_to_back;
`ifdef SOC_SYSID_UPTIME_EN
        test_uptime;
`endif
        test_random;
        test_reset_after_read;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
